// File: rtl/mips_cache_linefill_if.sv
// Memory-side Avalon read port shared by the line-fill engine and its memory slave.
interface mips_cache_linefill_if;
  logic [31:0] read_addr;
  logic        read;
  logic [3:0]  read_byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output read_addr, read, read_byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  read_addr, read, read_byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mips_cache_linefill.sv
// Data-cache line refill: waits for the write buffer to drain, then fetches one line
// critical word first over Avalon, wrapping inside the line.
module mips_cache_linefill #(
  parameter  int unsigned LINE_WORDS = 4,
  localparam int unsigned IDX_BITS   = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [31:0]         req_addr,
  input  logic                wb_empty,
  output logic                busy,
  output logic                done,
  output logic                fill_valid,
  output logic [IDX_BITS-1:0] fill_idx,
  output logic [31:0]         fill_data,
  output logic                fill_critical,
  mips_cache_linefill_if.master av
);

  localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state, state_nxt;
  logic [TAG_BITS-1:0] tag, tag_nxt;
  logic [IDX_BITS-1:0] idx, idx_nxt;
  logic [IDX_BITS-1:0] count, count_nxt;

  logic                busy_nxt, done_nxt, fill_valid_nxt, fill_critical_nxt;
  logic [IDX_BITS-1:0] fill_idx_nxt;
  logic [31:0]         fill_data_nxt;
  logic                read_nxt;
  logic [3:0]          byteenable_nxt;
  logic [31:0]         read_addr_nxt;

  // Byte offset bits of the miss address never affect a word-granular refill.
  logic unused_byte_offset;
  assign unused_byte_offset = ^req_addr[1:0];

  // Next-state and next-output logic; every register holds unless a branch updates it.
  always_comb begin
    state_nxt         = state;
    tag_nxt           = tag;
    idx_nxt           = idx;
    count_nxt         = count;
    busy_nxt          = busy;
    done_nxt          = 1'b0;
    fill_valid_nxt    = 1'b0;
    fill_critical_nxt = 1'b0;
    fill_idx_nxt      = fill_idx;
    fill_data_nxt     = fill_data;
    read_nxt          = av.read;
    byteenable_nxt    = av.read_byteenable;
    read_addr_nxt     = av.read_addr;

    case (state)
      IDLE: begin
        if (req) begin
          tag_nxt   = req_addr[31:IDX_BITS+2];
          idx_nxt   = req_addr[IDX_BITS+1:2];
          count_nxt = '0;
          busy_nxt  = 1'b1;
          if (wb_empty) begin
            state_nxt      = READ;
            read_nxt       = 1'b1;
            byteenable_nxt = 4'hF;
            read_addr_nxt  = {req_addr[31:2], 2'b00};
          end else begin
            state_nxt = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (wb_empty) begin
          state_nxt      = READ;
          read_nxt       = 1'b1;
          byteenable_nxt = 4'hF;
          read_addr_nxt  = {tag, idx, 2'b00};
        end
      end

      READ: begin
        if (!av.waitrequest) begin
          fill_valid_nxt    = 1'b1;
          fill_data_nxt     = av.readdata;
          fill_idx_nxt      = idx;
          fill_critical_nxt = (count == '0);
          idx_nxt           = idx + IDX_BITS'(1);
          count_nxt         = count + IDX_BITS'(1);
          // Last word: drop the read so no address is issued twice.
          if (count == IDX_BITS'(LINE_WORDS - 1)) begin
            state_nxt      = DONE;
            done_nxt       = 1'b1;
            read_nxt       = 1'b0;
            byteenable_nxt = 4'h0;
          end else begin
            read_addr_nxt = {tag, idx_nxt, 2'b00};
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      tag                <= '0;
      idx                <= '0;
      count              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      fill_valid         <= 1'b0;
      fill_critical      <= 1'b0;
      fill_idx           <= '0;
      fill_data          <= '0;
      av.read            <= 1'b0;
      av.read_byteenable <= 4'h0;
      av.read_addr       <= '0;
    end else begin
      state              <= state_nxt;
      tag                <= tag_nxt;
      idx                <= idx_nxt;
      count              <= count_nxt;
      busy               <= busy_nxt;
      done               <= done_nxt;
      fill_valid         <= fill_valid_nxt;
      fill_critical      <= fill_critical_nxt;
      fill_idx           <= fill_idx_nxt;
      fill_data          <= fill_data_nxt;
      av.read            <= read_nxt;
      av.read_byteenable <= byteenable_nxt;
      av.read_addr       <= read_addr_nxt;
    end
  end

endmodule

// File: doc/mips_cache_linefill.md
Name: mips_cache_linefill

Overview:
Avalon read master that refills one cache line on a data-cache miss. Fetches LINE_WORDS consecutive 32-bit words, critical word first, wrapping within the line. Presents each word to the cache data array as it arrives. Sits beside the cache write buffer on the same memory-side Avalon port. Before issuing any read it waits for the write buffer to drain, so a refill never returns data older than a buffered store.

Parameters:
LINE_WORDS, 4, words per cache line; power of two, minimum 2.
IDX_BITS, $clog2(LINE_WORDS), width of the word index within a line; derived, never overridden.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req  input  1  refill request; sampled only in IDLE
req_addr  input  32  miss address (byte address)
wb_empty  input  1  write buffer empty flag
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the line is complete
fill_valid  output  1  one-cycle strobe: fill_data/fill_idx valid
fill_idx  output  IDX_BITS  word index within line for fill_data
fill_data  output  32  returned word
fill_critical  output  1  high with fill_valid for the first (critical) word only
read_addr  output  32  Avalon address
read  output  1  Avalon read request
read_byteenable  output  4  Avalon byteenable; always 4'hF while read=1, else 4'h0
readdata  input  32  Avalon read data; valid in a cycle where read=1 and waitrequest=0
waitrequest  input  1  Avalon stall

Behaviour:
- Reset: state IDLE. Clears the following outputs and registers to 0 on the next edge: busy, done, fill_valid, fill_idx, fill_data, fill_critical, read, read_addr, read_byteenable, count, idx. Reset mid-refill abandons the line; no done pulse follows; read drops on the reset edge.
- Request acceptance: in IDLE at an edge with req=1:
  - latch line_base = req_addr with bits [IDX_BITS+1:0] cleared;
  - idx = req_addr[IDX_BITS+1:2]; count = 0;
  - next state READ if wb_empty=1, else DRAIN.
  - req is ignored in all non-IDLE states.
- DRAIN: read=0. Stays in DRAIN until an edge with wb_empty=1, then moves to READ. wb_empty is checked only at entry; later changes in READ have no effect.
- READ:
  - read=1, read_byteenable=4'hF, read_addr = line_base | (idx<<2).
  - These values are registered and stable while waitrequest=1.
  - At an edge with waitrequest=0, the word is accepted:
    - next cycle: fill_valid=1, fill_data=readdata, fill_idx=idx, fill_critical=(count==0);
    - idx <= idx+1, modulo LINE_WORDS (wrap within line; the upper address bits never change);
    - count <= count+1.
  - On the accept edge where count==LINE_WORDS-1:
    - read <= 0, read_byteenable <= 0, state <= DONE.
  - Otherwise read stays high and read_addr advances: back-to-back, one word per cycle at zero wait.
- DONE: done=1 for exactly one cycle; this coincides with the last fill_valid. Next edge goes to IDLE. A req present in the DONE cycle is not accepted; it is accepted at the following edge if still high.
- fill_valid, done and fill_critical are single-cycle pulses; they are 0 in all other cycles.
- busy is registered: it goes high the cycle after req is accepted and low the cycle after DONE.
- Latency, wb_empty=1 and waitrequest=0 throughout:
  - req sampled at edge 0;
  - word k accepted at edge k+1;
  - done high in the cycle after edge LINE_WORDS;
  - busy high for LINE_WORDS+1 cycles.
- Exactly LINE_WORDS reads are issued per request, each address exactly once.

Test Plan:
1. Aligned miss, LINE_WORDS=4, req_addr=0x0000_1000, wb_empty=1, waitrequest=0 -> read_addr sequence 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles. fill_idx 0,1,2,3 with fill_critical only on idx 0. done one cycle after the 4th accept edge; busy high 5 cycles.
2. Critical-word wrap, req_addr=0x0000_2008 -> addresses 0x2008, 0x200C, 0x2000, 0x2004. fill_idx 2,3,0,1; fill_critical with idx 2; no address outside 0x2000-0x200F.
3. Waitrequest stalls: waitrequest=1 for 3 cycles on the second word -> read_addr and read held constant for those cycles. No fill_valid during the stall. fill_data equals readdata sampled on the releasing edge. Total busy = 5+3 cycles.
4. Drain: req with wb_empty=0 for 4 cycles, then 1 -> read stays 0 while wb_empty=0. First read asserted the cycle after wb_empty rises. Dropping wb_empty during READ has no effect.
5. Reset mid-refill: rst after the 2nd accepted word -> read=0, busy=0, no done, no further fill_valid. A new req with req_addr=0x3004 then refills correctly from 0x3004.
6. Back-to-back requests: req held high through DONE -> second refill is accepted the edge after DONE, never in the DONE cycle. Two done pulses total, with one idle cycle between them.
